// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out word assembler with a small FWFT output FIFO.
// The MSB of each word arrives first; completed words are held for a valid/ready consumer.
module sipo_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          shift,
  input  logic                          data_in,
  input  logic                          clear,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          word_pending,
  output logic                          overflow
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [DATA_WIDTH-1:0] word;
  logic                  word_done;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign word      = {shift_reg[DATA_WIDTH-2:0], data_in};
  assign word_done = shift & ~clear & (bit_cnt == LAST);
  assign full      = (fifo_count == DEPTH_C);
  assign pop       = data_valid & out_ready & ~clear;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push      = word_done & (~full | pop);
  assign drop      = word_done & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (shift) begin
      shift_reg <= word;
      bit_cnt   <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     overflow <= 1'b0;
    else if (clear) overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

  // Storage needs no reset; the empty mask hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  assign data_valid   = (fifo_count != '0);
  assign data_out     = data_valid ? mem[rd_ptr] : '0;
  assign word_pending = (bit_cnt != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomised and directed bench for sipo_deserializer.
// A queue-based word model feeds a scoreboard checked by a negedge monitor.
module tb_sipo_deserializer;

  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          shift;
  logic          data_in;
  logic          clear;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [2:0]    fifo_count;
  logic          word_pending;
  logic          overflow;

  sipo_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift        (shift),
    .data_in      (data_in),
    .clear        (clear),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .fifo_count   (fifo_count),
    .word_pending (word_pending),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [$];
  int            mcount = 0;
  int            nb = 0;
  logic [DW-1:0] acc = '0;
  logic          movf = 1'b0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mcount = 0;
    nb = 0;
    acc = '0;
    movf = 1'b0;
  endtask

  // Word-level behaviour of one clock edge.
  task automatic model_edge(input logic s, input logic b,
                            input logic c, input logic r);
    int  pre;
    logic popped;
    if (c) begin
      model_reset();
      return;
    end
    pre = mcount;
    popped = (mcount > 0) && r;
    if (popped) mcount--;
    if (s) begin
      acc = {acc[DW-2:0], b};
      nb++;
      if (nb == DW) begin
        nb = 0;
        if (pre < DEPTH || popped) begin
          exp_q.push_back(acc);
          mcount++;
        end else begin
          movf = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input logic s, input logic b,
                       input logic c, input logic r);
    shift = s;
    data_in = b;
    clear = c;
    out_ready = r;
    @(posedge clk);
    model_edge(s, b, c, r);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap,
                           input logic r, input logic r_last);
    for (int i = DW - 1; i >= 0; i--) begin
      cycle(1'b1, w[i], 1'b0, (i == 0) ? r_last : r);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, r);
        if (gap > 0) chk("gap_pending", word_pending, 1);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] e;
    chk("valid", data_valid, mcount > 0);
    chk("count", fifo_count, mcount);
    chk("ovf", overflow, movf);
    chk("pending", word_pending, nb != 0);
    if (!data_valid) chk("zero_mask", data_out, 0);
    if (rst_n && data_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %0h expected none", data_out);
      end else begin
        e = exp_q.pop_front();
        chk("head", data_out, e);
      end
    end
  end

  initial begin
    logic [DW-1:0] piso;
    logic          line;
    logic          line_v;
    rst_n = 1'b0;
    shift = 1'b0;
    data_in = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", data_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", data_out, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_word(8'hA5, 0, 1'b1, 1'b1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_valid", data_valid, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_gone", data_valid, 0);

    send_word(8'h3C, 2, 1'b1, 1'b1);
    chk("3c_data", data_out, 8'h3C);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    send_word(8'h11, 0, 1'b0, 1'b0);
    send_word(8'h22, 0, 1'b0, 1'b0);
    send_word(8'h33, 0, 1'b0, 1'b0);
    send_word(8'h44, 0, 1'b0, 1'b0);
    send_word(8'h55, 0, 1'b0, 1'b0);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    repeat (DEPTH + 1) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", overflow, 0);
    send_word(8'h01, 0, 1'b0, 1'b0);
    send_word(8'h02, 0, 1'b0, 1'b0);
    send_word(8'h03, 0, 1'b0, 1'b0);
    send_word(8'h04, 0, 1'b0, 1'b0);
    send_word(8'h66, 0, 1'b0, 1'b1);
    chk("pt_ovf", overflow, 0);
    chk("pt_count", fifo_count, 4);
    repeat (DEPTH + 1) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_pending", word_pending, 0);
    send_word(8'h96, 0, 1'b0, 1'b0);
    chk("clr_data", data_out, 8'h96);
    chk("clr_count", fifo_count, 1);
    chk("clr_ovf2", overflow, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    send_word(8'h5A, 0, 1'b0, 1'b0);
    send_word(8'hE7, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, i[0], 1'b0, 1'b0);
    shift = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", data_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_pend", word_pending, 0);
    chk("arst_data", data_out, 0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(8'hC3, 0, 1'b0, 1'b0);
    chk("post_rst", data_out, 8'hC3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    piso = 8'hC3;
    line = 1'b0;
    line_v = 1'b0;
    for (int i = 0; i <= DW; i++) begin
      cycle(line_v, line, 1'b0, 1'b0);
      line_v = (i < DW);
      line = piso[DW-1];
      piso = {piso[DW-2:0], 1'b0};
    end
    chk("loopback", data_out, 8'hC3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1);

    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
